// File: rtl/move_referee_pkg.sv
// Shared definitions for the move referee: cell codes, FSM states and a
// helper that maps a player to the code written into a board cell.
package move_referee_pkg;

    // Two-bit encoding of one board cell
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    // Player identifiers as driven on move_player / turn
    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;

    // Referee control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Cell code a committed move leaves behind for the given player
    function automatic logic [1:0] player_cell(input logic player);
        return (player == PLAYER_O) ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/move_referee_cell_conflict_check.sv
// Combinational legality helper: reports whether a requested target cell is
// already occupied and whether the position vector is not exactly one-hot.
module cell_conflict_check
    import move_referee_pkg::*;
#(
    parameter int N_CELLS = 9
) (
    input  logic [2*N_CELLS-1:0] board,
    input  logic [N_CELLS-1:0]   move_pos,
    output logic                 occupied,
    output logic                 not_onehot
);

    localparam logic [N_CELLS-1:0] POS_ONE = {{(N_CELLS-1){1'b0}}, 1'b1};

    logic [N_CELLS-1:0] cell_used;
    logic [N_CELLS-1:0] pos_minus_one;

    // One flag per cell: set when the cell holds any non-empty code
    generate
        for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_used
            assign cell_used[gi] = (board[2*gi +: 2] != CELL_EMPTY);
        end
    endgenerate

    assign pos_minus_one = move_pos - POS_ONE;

    // A target hits an occupied cell if any requested bit lands on a used cell
    assign occupied = |(cell_used & move_pos);

    // Zero or more than one bit set: x & (x-1) clears the lowest set bit
    assign not_onehot = (move_pos == '0) || ((move_pos & pos_minus_one) != '0);

endmodule

// File: rtl/move_referee.sv
// Move referee: accepts one move per handshake, validates it against the
// current board and turn one cycle later, then commits or rejects it with a
// single pulse. Optional illegal-move counter enabled by the macro
// MOVE_REFEREE_ERR_CNT_EN (adds output err_count).
module move_referee
    import move_referee_pkg::*;
#(
    parameter int N_CELLS = 9,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 move_valid,
    output logic                 move_ready,
    input  logic [N_CELLS-1:0]   move_pos,
    input  logic                 move_player,
    output logic [2*N_CELLS-1:0] board,
    output logic                 accept,
    output logic                 illegal_move,
    output logic                 turn,
    output logic [CNT_W-1:0]     move_count,
    output logic                 board_full
`ifdef MOVE_REFEREE_ERR_CNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(N_CELLS);
    localparam logic [CNT_W-1:0] COUNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_next;

    // Move captured on the handshake, judged during CHECK
    logic [N_CELLS-1:0]   pos_reg;
    logic                 player_reg;

    logic [2*N_CELLS-1:0] board_reg;
    logic [2*N_CELLS-1:0] board_next;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic                 turn_reg;
    logic                 accept_reg;
    logic                 illegal_reg;

    logic                 occupied;
    logic                 not_onehot;
    logic                 move_bad;
    logic                 handshake;
    logic                 do_commit;
    logic                 do_reject;

    cell_conflict_check #(
        .N_CELLS(N_CELLS)
    ) u_conflict (
        .board      (board_reg),
        .move_pos   (pos_reg),
        .occupied   (occupied),
        .not_onehot (not_onehot)
    );

    // Board image with the captured move written in; only used on a legal
    // (hence one-hot) move, so exactly one cell changes
    generate
        for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_write
            assign board_next[2*gi +: 2] = pos_reg[gi] ? player_cell(player_reg)
                                                       : board_reg[2*gi +: 2];
        end
    endgenerate

    assign count_next = count_reg + COUNT_ONE;
    assign move_bad   = not_onehot || occupied || (player_reg != turn_reg);
    assign handshake  = move_valid && move_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, ready and commit/reject decisions; clear overrides everything
    always_comb begin
        state_next = state;
        move_ready = 1'b0;
        do_commit  = 1'b0;
        do_reject  = 1'b0;
        case (state)
            ST_IDLE: begin
                move_ready = rst_n && !clear;
                if (move_valid && !clear) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (move_bad) begin
                    do_reject = 1'b1;
                end else begin
                    do_commit = 1'b1;
                    if (count_next == FULL_COUNT) begin
                        state_next = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                state_next = ST_FULL;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_next = ST_IDLE;
            do_commit  = 1'b0;
            do_reject  = 1'b0;
        end
    end

    // Board, counters, turn, captured move and result pulses
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            board_reg   <= '0;
            count_reg   <= '0;
            turn_reg    <= PLAYER_X;
            pos_reg     <= '0;
            player_reg  <= 1'b0;
            accept_reg  <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            accept_reg  <= do_commit;
            illegal_reg <= do_reject;
            if (handshake) begin
                pos_reg    <= move_pos;
                player_reg <= move_player;
            end
            if (do_commit) begin
                board_reg <= board_next;
                count_reg <= count_next;
                turn_reg  <= ~turn_reg;
            end
        end
    end

`ifdef MOVE_REFEREE_ERR_CNT_EN
    // Saturating tally of rejected moves
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            err_count <= 8'd0;
        end else if (do_reject && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

    assign board        = board_reg;
    assign move_count   = count_reg;
    assign turn         = turn_reg;
    assign accept       = accept_reg;
    assign illegal_move = illegal_reg;
    assign board_full   = (count_reg == FULL_COUNT);

endmodule

// File: tb/tb_move_referee.sv
// Scoreboard bench for move_referee: a driver applies directed and random
// moves while a cell-array reference model predicts each verdict; a monitor
// pops predictions whenever the DUT pulses accept or illegal_move.
module tb_move_referee;

    localparam int N  = 9;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic           move_valid;
    logic           move_ready;
    logic [N-1:0]   move_pos;
    logic           move_player;
    logic [2*N-1:0] board;
    logic           accept;
    logic           illegal_move;
    logic           turn;
    logic [CW-1:0]  move_count;
    logic           board_full;
`ifdef MOVE_REFEREE_ERR_CNT_EN
    logic [7:0]     err_count;
`endif

    always #5 clk = ~clk;

    move_referee #(
        .N_CELLS(N),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .move_valid   (move_valid),
        .move_ready   (move_ready),
        .move_pos     (move_pos),
        .move_player  (move_player),
        .board        (board),
        .accept       (accept),
        .illegal_move (illegal_move),
        .turn         (turn),
        .move_count   (move_count),
        .board_full   (board_full)
`ifdef MOVE_REFEREE_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit             is_accept;
        logic [2*N-1:0] board;
        bit             turn;
        int             count;
        int             due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model: game as plain arrays and integers
    int             cells[N];   // 0 empty, 1 X, 2 O
    bit             m_turn;
    int             m_count;
    bit             m_busy;     // a move is being judged this cycle
    bit             m_full;
    logic [N-1:0]   pend_pos;
    bit             pend_player;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [2*N-1:0] pack_board();
        logic [2*N-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            b[2*i +: 2] = (cells[i] == 1) ? 2'b01 : (cells[i] == 2) ? 2'b10 : 2'b00;
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) cells[i] = 0;
        m_turn  = 0;
        m_count = 0;
        m_busy  = 0;
        m_full  = 0;
    endtask

    // Decide the pending move from the game rules and queue the verdict
    task automatic judge();
        exp_t e;
        int   idx;
        bit   ok;
        idx = -1;
        for (int i = 0; i < N; i++) if (pend_pos[i]) idx = i;
        ok = ($countones(pend_pos) == 1) && (cells[idx] == 0) && (pend_player == m_turn);
        if (ok) begin
            cells[idx] = pend_player ? 2 : 1;
            m_count++;
            m_turn = !m_turn;
        end
        e.is_accept = ok;
        e.board     = pack_board();
        e.turn      = m_turn;
        e.count     = m_count;
        e.due       = cyc + 1;
        sb.push_back(e);
        m_full = (m_count == N);
    endtask

    // One clock cycle of stimulus; model advances to match the coming edge
    task automatic step(bit v, logic [N-1:0] p, bit pl, bit clr, bit rst);
        @(negedge clk);
        move_valid  = v;
        move_pos    = p;
        move_player = pl;
        clear       = clr;
        rst_n       = !rst;
        #1;
        check("move_ready", move_ready, (!rst && !clr && !m_busy && !m_full));
        check("board_full", board_full, (m_count == N));
        if (rst || clr) begin
            model_reset();
        end else if (m_busy) begin
            judge();
            m_busy = 0;
        end else if (!m_full && v) begin
            pend_pos    = p;
            pend_player = pl;
            m_busy      = 1;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
    endtask

    task automatic mv(logic [N-1:0] p, bit pl);
        step(1, p, pl, 0, 0);
        idle(2);
    endtask

    // Monitor: every result pulse must match the oldest prediction
    always @(negedge clk) begin
        if (accept === 1'b1 && illegal_move === 1'b1) begin
            total++;
            bad++;
            $display("FAIL both_pulses: accept=1 illegal_move=1 at cycle %0d", cyc);
        end
        if (accept === 1'b1 || illegal_move === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: accept=%0b illegal_move=%0b, none expected (cycle %0d)",
                         accept, illegal_move, cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("txn cycle=%0d result=%s board=%05h turn=%0b count=%0d",
                         cyc, accept ? "accept" : "illegal", board, turn, move_count);
                check("pulse_kind",  accept,     mon_e.is_accept);
                check("pulse_cycle", cyc,        mon_e.due);
                check("board",       board,      mon_e.board);
                check("turn",        turn,       mon_e.turn);
                check("move_count",  move_count, mon_e.count);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_pulse: no pulse, required %s at cycle %0d",
                     mon_e.is_accept ? "accept" : "illegal_move", mon_e.due);
        end
    end

    initial begin
        logic [N-1:0] p;
        bit           pl;
        int           r;

        rst_n       = 1'b0;
        clear       = 1'b0;
        move_valid  = 1'b0;
        move_pos    = '0;
        move_player = 1'b0;
        model_reset();

        // Reset values
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        check("rst_board", board, '0);
        check("rst_turn", turn, 1'b0);
        check("rst_count", move_count, '0);
        check("rst_accept", accept, 1'b0);
        check("rst_illegal", illegal_move, 1'b0);
        check("rst_full", board_full, 1'b0);
        idle(1);

        // X on cell 0, O collides on cell 0, O on cell 4
        mv(9'h001, 0);
        check("x_cell0", board[1:0], 2'b01);
        check("x_turn", turn, 1'b1);
        check("x_count", move_count, 4'd1);
        mv(9'h001, 1);
        mv(9'h010, 1);
        check("o_cell4", board[9:8], 2'b10);

        // Zero and multi-hot positions, then X out of turn
        mv(9'h000, 0);
        mv(9'h003, 0);
        mv(9'h002, 0);
        mv(9'h004, 0);

        // Fill the board from scratch
        step(0, '0, 0, 1, 0);
        for (int i = 0; i < N; i++) begin
            p = '0;
            p[i] = 1'b1;
            mv(p, (i % 2) == 1);
        end
        check("full_count", move_count, 4'd9);
        check("full_flag", board_full, 1'b1);
        check("full_ready", move_ready, 1'b0);
        step(1, 9'h001, 1, 0, 0);
        step(1, 9'h100, 0, 0, 0);
        idle(3);

        // Clear with a same-cycle handshake, then clear while judging
        step(0, '0, 0, 1, 0);
        step(1, 9'h001, 0, 1, 0);
        idle(2);
        step(1, 9'h001, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        idle(3);
        check("clr_board", board, '0);
        check("clr_turn", turn, 1'b0);
        check("clr_count", move_count, '0);

        // Reset while a move is in flight
        step(1, 9'h008, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        idle(3);

        // Random play
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            p = '0;
            if (r == 1) p = N'($urandom);
            else if (r != 0) p[$urandom_range(0, N-1)] = 1'b1;
            pl = ($urandom_range(0, 4) == 0) ? !m_turn : m_turn;
            step($urandom_range(0, 9) < 7, p, pl,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end
        idle(3);

`ifdef MOVE_REFEREE_ERR_CNT_EN
        step(0, '0, 0, 1, 0);
        for (int n = 0; n < 300; n++) mv(9'h001, 1);
        check("err_sat", err_count, 8'd255);
        step(0, '0, 0, 1, 0);
        idle(1);
        check("err_clear", err_count, 8'd0);
`endif

        idle(4);
        check("queue_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
